// File: rtl/seg7_pkg.sv
// seg7_pkg: segment decode table, dp position and inactive output levels shared by the display controller.
package seg7_pkg;
    localparam int DP_BIT = 7;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7:0]  SEG_IDLE_AH = 8'h00;
    localparam logic [7:0]  SEG_IDLE_AL = 8'hFF;
    localparam logic [15:0] CS_IDLE_AH  = 16'h0000;
    localparam logic [15:0] CS_IDLE_AL  = 16'hFFFF;
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: addressed digit write port of the scanning display controller.
interface seg7_scan_ctrl_if #(parameter int DIG_W = 3);
    logic             wr_en;
    logic [DIG_W-1:0] wr_addr;
    logic [3:0]       wr_data;
    logic             wr_dp;
    modport master (output wr_en, wr_addr, wr_data, wr_dp);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_dp);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit hex value to active-high g..a segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[val];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multi-digit 7-segment scan controller with prescaler, leading-zero blanking,
// PWM brightness, selectable output polarity and a frame strobe.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DIG_W          = $clog2(NUM_DIGITS),
    parameter int SCAN_DIV       = 50000,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 0,
    parameter bit CS_ACTIVE_LOW  = 0
)
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    seg7_scan_ctrl_if.slave       wr,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] cs_out,
    output logic [DIG_W-1:0]      scan_idx,
    output logic                  frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = PW + BRIGHT_W + 1;
    localparam logic [PW-1:0]         P_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]      IDX_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIG_W:0]        ND       = (DIG_W + 1)'(NUM_DIGITS);
    localparam logic [7:0]            SEG_IDLE = SEG_ACTIVE_LOW ? SEG_IDLE_AL : SEG_IDLE_AH;
    localparam logic [NUM_DIGITS-1:0] CS_IDLE  = CS_ACTIVE_LOW ? CS_IDLE_AL[NUM_DIGITS-1:0]
                                                               : CS_IDLE_AH[NUM_DIGITS-1:0];

    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp;
    logic [PW-1:0]         presc;
    logic [BRIGHT_W-1:0]   bright_q, bright_eff;
    logic [NUM_DIGITS-1:0] lz;
    logic [6:0]            seg_dec;
    logic [7:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] cs_nxt;
    logic                  lit, wrap, show;

    assign wrap       = en && presc == P_LAST;
    // Slot start uses the live input so the first cycle already reflects the new sample.
    assign bright_eff = presc == '0 ? bright : bright_q;
    assign lit        = (CW'(presc) << BRIGHT_W) < (CW'(bright_eff) + CW'(1)) * CW'(SCAN_DIV);
    assign show       = en && lit;
    assign cs_nxt     = NUM_DIGITS'(1) << scan_idx;

    always_comb begin
        logic z;
        z  = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z     = z && digit[i] == 4'd0;
            lz[i] = z;
        end
    end

    seg7_hex_decode u_dec (.val(digit[scan_idx]), .seg(seg_dec));

    always_comb begin
        seg_nxt         = {1'b0, (blank_lz && lz[scan_idx]) ? 7'd0 : seg_dec};
        seg_nxt[DP_BIT] = dp[scan_idx];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
            dp         <= '0;
            presc      <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
            bright_q   <= '0;
            seg_out    <= SEG_IDLE;
            cs_out     <= CS_IDLE;
        end else begin
            if (wr.wr_en && {1'b0, wr.wr_addr} < ND) begin
                digit[wr.wr_addr] <= wr.wr_data;
                dp[wr.wr_addr]    <= wr.wr_dp;
            end
            if (en) presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) scan_idx <= scan_idx == IDX_LAST ? '0 : scan_idx + 1'b1;
            if (presc == '0) bright_q <= bright;
            frame_tick <= wrap && scan_idx == IDX_LAST;
            seg_out    <= show ? seg_nxt ^ SEG_IDLE : SEG_IDLE;
            cs_out     <= show ? cs_nxt ^ CS_IDLE : CS_IDLE;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scenarios push timed expectations into a scoreboard; a negedge monitor compares them.
module tb_seg7_scan_ctrl;
    logic       sys_clk = 1'b0, sys_rst = 1'b1, en = 1'b0, en6 = 1'b0, blank_lz = 1'b0;
    logic [3:0] bright = 4'hF;
    logic [7:0] seg8, seg6, cs8;
    logic [5:0] cs6;
    logic [2:0] idx8, idx6;
    logic       tick8, tick6;
    int         cyc = 0, c0 = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    logic [7:0] dec_exp [8] = '{8'h06, 8'h5B, 8'hCF, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    logic [7:0] lz_exp  [8] = '{8'h3F, 8'h3F, 8'h5B, 8'h3F, 8'h06, 8'h00, 8'h80, 8'h00};

    seg7_scan_ctrl_if #(.DIG_W(3)) wif8 ();
    seg7_scan_ctrl_if #(.DIG_W(3)) wif6 ();

    seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(16), .BRIGHT_W(4)) u8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .wr(wif8), .blank_lz(blank_lz),
        .bright(bright), .seg_out(seg8), .cs_out(cs8), .scan_idx(idx8), .frame_tick(tick8)
    );
    seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(16), .BRIGHT_W(4)) u6 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en6), .wr(wif6), .blank_lz(blank_lz),
        .bright(bright), .seg_out(seg6), .cs_out(cs6), .scan_idx(idx6), .frame_tick(tick6)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int s);
        case (s)
            0: return 32'(seg8);
            1: return 32'(cs8);
            2: return 32'(idx8);
            3: return 32'(tick8);
            4: return 32'(seg6);
            5: return 32'(cs6);
            6: return 32'(idx6);
            default: return 32'(tick6);
        endcase
    endfunction

    always @(negedge sys_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_cmp++;
                if (actual(sb[i].sig) !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, cyc, actual(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic want(int at, int s, logic [31:0] v, string nm);
        exp_t e;
        e.at = at; e.sig = s; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; en = 1'b0; en6 = 1'b0; wif8.wr_en = 1'b0; wif6.wr_en = 1'b0;
        tick(3);
        sys_rst = 1'b0;
    endtask

    task automatic start();
        en = 1'b1; en6 = 1'b1; c0 = cyc;
    endtask

    task automatic wr8(int a, int d, logic p);
        wif8.wr_en = 1'b1; wif8.wr_addr = 3'(a); wif8.wr_data = 4'(d); wif8.wr_dp = p;
        tick();
        wif8.wr_en = 1'b0;
    endtask

    task automatic wr6(int a, int d, logic p);
        wif6.wr_en = 1'b1; wif6.wr_addr = 3'(a); wif6.wr_data = 4'(d); wif6.wr_dp = p;
        tick();
        wif6.wr_en = 1'b0;
    endtask

    initial begin
        wif8.wr_en = 1'b0; wif8.wr_addr = '0; wif8.wr_data = '0; wif8.wr_dp = 1'b0;
        wif6.wr_en = 1'b0; wif6.wr_addr = '0; wif6.wr_data = '0; wif6.wr_dp = 1'b0;
        // Reset values, then a full scan with all digits zero at full brightness.
        do_reset();
        n_cmp++;
        if (seg8 !== 8'h00 || cs8 !== 8'h00 || idx8 !== 3'd0 || tick8 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_direct seg=%0h cs=%0h idx=%0d tick=%0b", seg8, cs8, idx8, tick8);
        end
        n_cmp++;
        if (seg6 !== 8'h00 || cs6 !== 6'h00 || idx6 !== 3'd0 || tick6 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst6_direct seg=%0h cs=%0h idx=%0d tick=%0b", seg6, cs6, idx6, tick6);
        end
        want(cyc, 0, 0, "rst_seg"); want(cyc, 1, 0, "rst_cs");
        want(cyc, 2, 0, "rst_idx"); want(cyc, 3, 0, "rst_tick");
        start();
        for (int d = 0; d < 8; d++) begin
            want(c0 + 16*d + 1, 1, 1 << d, "scan_cs");
            want(c0 + 16*d + 1, 0, 'h3F, "scan_seg");
            want(c0 + 16*d + 16, 1, 1 << d, "scan_cs_end");
            want(c0 + 16*d + 1, 2, d, "scan_idx");
        end
        want(c0 + 127, 3, 0, "tick_pre"); want(c0 + 128, 3, 1, "tick");
        want(c0 + 129, 3, 0, "tick_post"); want(c0 + 256, 3, 1, "tick2");
        tick(260);
        // Write/decode with dp on digit 2, then a write to the digit on display.
        do_reset();
        for (int d = 0; d < 8; d++) wr8(d, d + 1, d == 2);
        start();
        for (int d = 0; d < 8; d++) want(c0 + 16*d + 1, 0, dec_exp[d], "dec_seg");
        tick(130);
        want(c0 + 131, 0, 'h06, "wr_lat1"); want(c0 + 132, 0, 'h77, "wr_lat2");
        wr8(0, 'hA, 1'b0);
        tick(5);
        // Out-of-range writes on the 6-digit unit; en dropped mid-slot on the 8-digit unit.
        do_reset();
        wr6(7, 8, 1'b1); wr6(6, 8, 1'b1); wr6(5, 1, 1'b0);
        start();
        for (int d = 0; d < 6; d++) begin
            want(c0 + 16*d + 1, 4, d == 5 ? 'h06 : 'h3F, "oor_seg");
            want(c0 + 16*d + 1, 5, 1 << d, "oor_cs");
        end
        want(c0 + 95, 6, 5, "idx6_last"); want(c0 + 96, 6, 0, "idx6_wrap"); want(c0 + 96, 7, 1, "tick6");
        want(c0 + 21, 0, 0, "endrop_seg"); want(c0 + 21, 1, 0, "endrop_cs");
        want(c0 + 21, 2, 1, "endrop_idx"); want(c0 + 25, 2, 1, "enhold_idx");
        want(c0 + 25, 0, 0, "enhold_seg"); want(c0 + 25, 3, 0, "enhold_tick");
        want(c0 + 26, 1, 'h02, "enrise_cs"); want(c0 + 26, 0, 'h3F, "enrise_seg");
        want(c0 + 36, 2, 1, "resume_idx1"); want(c0 + 37, 2, 2, "resume_idx2");
        want(c0 + 37, 1, 'h02, "resume_cs1"); want(c0 + 38, 1, 'h04, "resume_cs2");
        tick(20); en = 1'b0;
        tick(5);  en = 1'b1;
        tick(80);
        // Leading-zero blanking, blanked digit keeps its dp.
        do_reset();
        blank_lz = 1'b1;
        wr8(4, 1, 1'b0); wr8(2, 2, 1'b0); wr8(6, 0, 1'b1);
        start();
        for (int d = 0; d < 8; d++) begin
            want(c0 + 16*d + 1, 0, lz_exp[d], "lz_seg");
            want(c0 + 16*d + 1, 1, 1 << d, "lz_cs");
        end
        tick(130);
        do_reset();
        start();
        for (int d = 0; d < 8; d++) begin
            want(c0 + 16*d + 8, 0, d == 0 ? 'h3F : 'h00, "lz0_seg");
            want(c0 + 16*d + 8, 1, 1 << d, "lz0_cs");
        end
        tick(130);
        blank_lz = 1'b0;
        // Brightness duty and slot-aligned sampling.
        do_reset();
        bright = 4'd3;
        start();
        for (int k = 1; k <= 16; k++) want(c0 + k, 1, k <= 4 ? 'h01 : 'h00, "b3_cs");
        want(c0 + 4, 0, 'h3F, "b3_seg_on"); want(c0 + 5, 0, 'h00, "b3_seg_off");
        tick(16);
        bright = 4'd0;
        want(c0 + 17, 1, 'h02, "b0_on"); want(c0 + 18, 1, 'h00, "b0_off"); want(c0 + 32, 1, 'h00, "b0_end");
        tick(17);
        bright = 4'hF;
        want(c0 + 34, 1, 'h00, "bmid_hold"); want(c0 + 48, 1, 'h00, "bmid_end");
        want(c0 + 49, 1, 'h08, "bnext_on"); want(c0 + 50, 1, 'h08, "bnext_2"); want(c0 + 64, 1, 'h08, "bnext_end");
        tick(35);
        // Reset during digit 5 with a concurrent write.
        do_reset();
        start();
        tick(83);
        sys_rst = 1'b1;
        wif8.wr_en = 1'b1; wif8.wr_addr = 3'd5; wif8.wr_data = 4'd8; wif8.wr_dp = 1'b1;
        want(c0 + 84, 0, 0, "mrst_seg"); want(c0 + 84, 1, 0, "mrst_cs");
        want(c0 + 84, 2, 0, "mrst_idx"); want(c0 + 84, 3, 0, "mrst_tick");
        tick();
        n_cmp++;
        if (seg8 !== 8'h00 || cs8 !== 8'h00 || idx8 !== 3'd0 || tick8 !== 1'b0) begin
            n_bad++;
            $display("FAIL mrst_direct seg=%0h cs=%0h idx=%0d tick=%0b", seg8, cs8, idx8, tick8);
        end
        sys_rst = 1'b0; wif8.wr_en = 1'b0; c0 = cyc;
        want(c0 + 81, 1, 'h20, "mrst_d5_cs"); want(c0 + 81, 0, 'h3F, "mrst_d5_seg"); want(c0 + 81, 2, 5, "mrst_d5_idx");
        tick(90);
        tick(2);
        @(negedge sys_clk);
        #1;
        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked (due cyc=%0d)", sb[i].name, sb[i].at);
        end
        if (n_bad != 0) $display("TEST FAILED");
        else $display("TEST PASSED");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
